seq_scheduler: RTL and testbench

SEQ_SCHEDULER -- requirements
Module: seq_scheduler

---
 rtl/seq_scheduler.sv | 218 +++++++++++++++++++++
 tb/tb_seq_scheduler.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_scheduler.sv
// Command-byte scheduler driving a pattern sequencer: SET_MODE / RUN / LOAD / ABORT.
// Optional load watchdog enabled by defining SEQ_SCHEDULER_TIMEOUT_EN.
module seq_scheduler #(
  parameter int SEQ_LEN = 64,
  parameter int GAP     = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_data,
  output logic       cmd_ready,
  output logic       seq_en,
  output logic [1:0] mode,
  output logic       wr,
  output logic       stb,
  output logic [7:0] dato,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [2:0] dbg_state
);

  // Handshake: a byte transfers on the rising clk edge where cmd_valid && cmd_ready.
  // SEQ_LEN >= 2 and GAP >= 1 are assumed: the pulse cycle counts toward SEQ_LEN.
  localparam int TMAX = (SEQ_LEN > GAP) ? SEQ_LEN : GAP;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] WAIT_LAST = TW'(SEQ_LEN - 2);
  localparam logic [TW-1:0] GAP_LAST  = TW'(GAP - 1);

  localparam logic [1:0] OP_SET_MODE = 2'b00;
  localparam logic [1:0] OP_RUN      = 2'b01;
  localparam logic [1:0] OP_LOAD     = 2'b10;
  localparam logic [1:0] OP_ABORT    = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LD_SETUP  = 3'd1,
    S_LD_STB    = 3'd2,
    S_LD_WAIT   = 3'd3,
    S_RUN_PULSE = 3'd4,
    S_RUN_WAIT  = 3'd5,
    S_RUN_GAP   = 3'd6
  } state_t;

  state_t          state;
  logic [7:0]      ld_cnt;
  logic [6:0]      rep_cnt;
  logic [TW-1:0]   tmr;
  logic            accept;
  logic [1:0]      opcode;
  logic            run_abort;
  logic            tmo_hit;

  assign accept    = cmd_valid & cmd_ready;
  assign opcode    = cmd_data[7:6];
  assign run_abort = accept && (opcode == OP_ABORT);
  assign dbg_state = state;

`ifdef SEQ_SCHEDULER_TIMEOUT_EN
  logic [15:0] tmo;

  // tmo holds the number of cycles since the last accepted byte (or since LOAD started),
  // so the IDLE-with-err cycle lands 65535 cycles after that acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo <= 16'd0;
    end else if (state == S_IDLE || accept) begin
      tmo <= 16'd0;
    end else if (state == S_LD_WAIT || state == S_LD_SETUP || state == S_LD_STB) begin
      tmo <= tmo + 16'd1;
    end
  end

  assign tmo_hit = (state == S_LD_WAIT) && !accept && (tmo == 16'hFFFE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (tmo_hit) begin
      err <= 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign err     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cmd_ready <= 1'b0;
      seq_en    <= 1'b0;
      mode      <= 2'b01;
      wr        <= 1'b0;
      stb       <= 1'b0;
      dato      <= 8'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      ld_cnt    <= 8'd0;
      rep_cnt   <= 7'd0;
      tmr       <= '0;
    end else begin
      seq_en <= 1'b0;
      stb    <= 1'b0;
      done   <= 1'b0;
      case (state)
        S_IDLE: begin
          cmd_ready <= 1'b1;
          if (accept) begin
            case (opcode)
              OP_SET_MODE: mode <= cmd_data[1:0];
              OP_RUN: begin
                rep_cnt <= (cmd_data[5:0] == 6'd0) ? 7'd64 : {1'b0, cmd_data[5:0]};
                seq_en  <= 1'b1;
                busy    <= 1'b1;
                state   <= S_RUN_PULSE;
              end
              OP_LOAD: begin
                wr     <= 1'b1;
                busy   <= 1'b1;
                ld_cnt <= 8'd0;
                state  <= S_LD_WAIT;
              end
              default: ;
            endcase
          end
        end

        // Every byte is pattern data here; ABORT is deliberately not decoded.
        S_LD_WAIT: begin
          if (accept) begin
            dato      <= cmd_data;
            cmd_ready <= 1'b0;
            state     <= S_LD_SETUP;
          end else if (tmo_hit) begin
            wr    <= 1'b0;
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end

        S_LD_SETUP: begin
          stb   <= 1'b1;
          state <= S_LD_STB;
        end

        S_LD_STB: begin
          cmd_ready <= 1'b1;
          ld_cnt    <= ld_cnt + 8'd1;
          if (ld_cnt == 8'd127) begin
            wr    <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_IDLE;
          end else begin
            state <= S_LD_WAIT;
          end
        end

        S_RUN_PULSE: begin
          if (run_abort) begin
            busy    <= 1'b0;
            rep_cnt <= 7'd0;
            state   <= S_IDLE;
          end else begin
            tmr   <= '0;
            state <= S_RUN_WAIT;
          end
        end

        // The final pass skips the gap and finishes straight from the wait.
        S_RUN_WAIT: begin
          if (run_abort) begin
            busy    <= 1'b0;
            rep_cnt <= 7'd0;
            tmr     <= '0;
            state   <= S_IDLE;
          end else if (tmr == WAIT_LAST) begin
            tmr <= '0;
            if (rep_cnt == 7'd1) begin
              rep_cnt <= 7'd0;
              busy    <= 1'b0;
              done    <= 1'b1;
              state   <= S_IDLE;
            end else begin
              state <= S_RUN_GAP;
            end
          end else begin
            tmr <= tmr + 1'b1;
          end
        end

        S_RUN_GAP: begin
          if (run_abort) begin
            busy    <= 1'b0;
            rep_cnt <= 7'd0;
            tmr     <= '0;
            state   <= S_IDLE;
          end else if (tmr == GAP_LAST) begin
            tmr     <= '0;
            rep_cnt <= rep_cnt - 7'd1;
            seq_en  <= 1'b1;
            state   <= S_RUN_PULSE;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end

        default: begin
          busy  <= 1'b0;
          wr    <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_scheduler.sv
// Directed bench for seq_scheduler; cycle 0 is the cycle right after a byte is accepted.
// Define SEQ_SCHEDULER_TIMEOUT_EN for both files to add the load-watchdog scenario.
module tb_seq_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [7:0] cmd_data = 8'd0;
  logic       cmd_ready;
  logic       seq_en;
  logic [1:0] mode;
  logic       wr;
  logic       stb;
  logic [7:0] dato;
  logic       busy;
  logic       done;
  logic       err;
  logic [2:0] dbg_state;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] exp_q[$];

  seq_scheduler #(.SEQ_LEN(64), .GAP(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_data  (cmd_data),
    .cmd_ready (cmd_ready),
    .seq_en    (seq_en),
    .mode      (mode),
    .wr        (wr),
    .stb       (stb),
    .dato      (dato),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // driver: returns just after the acceptance edge
  task automatic send_byte(input logic [7:0] b);
    int t;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_data  = b;
    t = 0;
    while (!cmd_ready && t < 1000) begin
      @(negedge clk);
      t++;
    end
    check("send_ready", (t < 1000), 1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic ld_byte(input logic [7:0] b, input logic last);
    send_byte(b);
    exp_q.push_back(b);
    @(negedge clk);
    check("ld_setup_stb", stb, 0);
    check("ld_setup_ready", cmd_ready, 0);
    @(negedge clk);
    check("ld_stb", stb, 1);
    check("ld_dato", dato, exp_q.pop_front());
    check("ld_seq_en", seq_en, 0);
    @(negedge clk);
    check("ld_stb_fall", stb, 0);
    check("ld_dato_hold", dato, b);
    check("ld_wr", wr, !last);
    check("ld_done", done, last);
    check("ld_busy", busy, !last);
  endtask

  task automatic run_check(input logic [7:0] b, input int reps, input int done_exp);
    int pulses, done_at, n_done, busy_n, wr_seen;
    pulses = 0; done_at = -1; n_done = 0; busy_n = 0; wr_seen = 0;
    send_byte(b);
    for (int c = 0; c < done_exp + 8; c++) begin
      @(negedge clk);
      if (seq_en) begin
        check("run_pulse_pos", c, pulses * 68);
        pulses++;
      end
      if (done) begin
        n_done++;
        if (done_at < 0) done_at = c;
      end
      if (busy) busy_n++;
      if (wr) wr_seen++;
      if (c == 0) check("run_busy_c0", busy, 1);
    end
    check("run_pulses", pulses, reps);
    check("run_done_at", done_at, done_exp);
    check("run_done_cnt", n_done, 1);
    check("run_busy_cycles", busy_n, done_exp);
    check("run_wr_low", wr_seen, 0);
    check("run_end_state", dbg_state, 3'd0);
  endtask

  initial begin
    int pulses, dones;

    // reset state
    repeat (2) @(negedge clk);
    check("rst_ready", cmd_ready, 0);
    check("rst_mode", mode, 2'b01);
    check("rst_outs", {seq_en, wr, stb, busy, done, err}, 6'b0);
    check("rst_dato", dato, 8'h00);
    check("rst_state", dbg_state, 3'd0);
    rst_n = 1'b1;
    #1 check("rst_ready_release", cmd_ready, 0);
    @(negedge clk);
    check("ready_first_edge", cmd_ready, 1);

    // SET_MODE
    send_byte(8'h02);
    @(negedge clk);
    check("mode_set", mode, 2'b10);
    check("mode_busy", busy, 0);
    check("mode_state", dbg_state, 3'd0);

    // RUN 3 reps, then 1 rep (no gap on the last pass)
    run_check(8'h43, 3, 200);
    run_check(8'h41, 1, 64);

    // LOAD 0x00..0x7F
    send_byte(8'h80);
    @(negedge clk);
    check("ld_enter_wr", wr, 1);
    check("ld_enter_busy", busy, 1);
    check("ld_enter_ready", cmd_ready, 1);
    check("ld_enter_seq_en", seq_en, 0);
    for (int i = 0; i < 128; i++) ld_byte(i[7:0], i == 127);
    check("ld_exit_state", dbg_state, 3'd0);
    check("ld_exit_mode", mode, 2'b10);

    // RUN 64 reps, stray SET_MODE at cycle 3, ABORT at cycle 10
    send_byte(8'h40);
    pulses = 0;
    dones = 0;
    for (int c = 0; c <= 10; c++) begin
      @(negedge clk);
      if (seq_en) pulses++;
      if (done) dones++;
      if (c == 10) check("abort_busy_pre", busy, 1);
      cmd_valid = (c == 3) || (c == 10);
      cmd_data  = (c == 10) ? 8'hC0 : 8'h01;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    check("abort_idle_c11", dbg_state, 3'd0);
    check("abort_busy_c11", busy, 0);
    check("abort_mode_kept", mode, 2'b10);
    for (int c = 0; c < 100; c++) begin
      if (seq_en) pulses++;
      if (done) dones++;
      @(negedge clk);
    end
    check("abort_pulses", pulses, 1);
    check("abort_no_done", dones, 0);

    // reset in the middle of the 51st LOAD byte
    send_byte(8'h80);
    for (int i = 0; i < 50; i++) ld_byte(8'hC0 + i[7:0], 1'b0);
    send_byte(8'hA5);
    @(negedge clk);
    @(negedge clk);
    check("mid_rst_pre_stb", stb, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_wr", wr, 0);
    check("mid_rst_stb", stb, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_dato", dato, 8'h00);
    dones = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) dones++;
    end
    rst_n = 1'b1;
    @(negedge clk);
    if (done) dones++;
    check("mid_rst_no_done", dones, 0);
    check("mid_rst_mode", mode, 2'b01);
    send_byte(8'h80);
    for (int i = 0; i < 128; i++) ld_byte(8'hFF - i[7:0], i == 127);

`ifdef SEQ_SCHEDULER_TIMEOUT_EN
    begin
      int c;
      send_byte(8'h80);
      for (int i = 0; i < 5; i++) ld_byte(8'h11 * (i[7:0] + 8'd1), 1'b0);
      c = 2;
      while (wr && c < 70000) begin
        @(negedge clk);
        c++;
      end
      check("tmo_cycle", c, 65535);
      check("tmo_err", err, 1);
      check("tmo_no_done", done, 0);
      check("tmo_busy", busy, 0);
      repeat (20) @(negedge clk);
      check("tmo_err_sticky", err, 1);
      rst_n = 1'b0;
      #1 check("tmo_err_rst", err, 0);
      @(negedge clk);
      rst_n = 1'b1;
    end
`else
    check("err_tied", err, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
